pkt_buffer_writer: RTL and testbench
====================================

Name: pkt_buffer_writer

Overview:
- Ingress-side writer for the on-chip packet buffer; it is the producer counterpart of the data mover that reads packets out and frees their IDs.
- Accepts an Ethernet RX flit stream and pops a free pktID from the packet emptylist.
- Writes each flit into slot (pktID<<5)+flit_index, then emits one metadata_t per packet to the data mover's metadata input.

Parameters:
- MAX_FLITS, 31, maximum flits stored per packet slot; must be ≤31 to fit metadata_t.flits (5 bits).
- FLAG_DEFAULT, PKT_ETH, pkt_flags used when in_pkt_flags_valid is low at SOP.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_pkt_sop  in  1  first flit of packet
- in_pkt_eop  in  1  last flit
- in_pkt_valid  in  1  flit valid
- in_pkt_data  in  512  flit payload
- in_pkt_empty  in  6  empty bytes in EOP flit
- in_pkt_flags  in  3  destination flag, sampled with SOP
- in_pkt_flags_valid  in  1  in_pkt_flags meaningful
- in_pkt_ready  out  1  flit accepted when valid&ready
- emptylist_out_data  in  PKT_AWIDTH  free pktID
- emptylist_out_valid  in  1  free ID available
- emptylist_out_ready  out  1  pop strobe
- pkt_buffer_address  out  PKTBUF_AWIDTH  write address
- pkt_buffer_write  out  1  write strobe
- pkt_buffer_writedata  out  flit_t  {data, sop, eop, empty}
- meta_valid  out  1  metadata valid
- meta_data  out  metadata_t  {pktID, flits, len, pkt_flags}
- meta_ready  in  1  consumer accepts
- stat_pkt_cnt  out  32  stored packets (feature)
- stat_drop_cnt  out  32  packets dropped for lack of ID (feature)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, ID prefetch register empty, counters 0. Reset mid-packet abandons the packet. The popped ID is not recovered; the emptylist is re-initialised after reset.
- ID prefetch:
  - one-entry register id_r/id_v.
  - emptylist_out_ready = !id_v | (ID consumed this cycle).
  - Pop fires when emptylist_out_valid & emptylist_out_ready; id_v is set on the next edge.
- States: IDLE, RECV, DISCARD, META.
- IDLE:
  - in_pkt_ready = 1.
  - On an accepted SOP flit with id_v=1: consume id_r, latch flags (in_pkt_flags if valid, else FLAG_DEFAULT), flit_idx=1, write flit at {id_r,5'd0}. Go to RECV, or META if EOP is on the same flit.
  - SOP with id_v=0: drop the flit, increment drop count, go to DISCARD (or stay IDLE if EOP).
  - Non-SOP flits in IDLE are discarded silently.
- RECV:
  - in_pkt_ready = 1.
  - Each accepted flit with flit_idx<MAX_FLITS is written at {pktID,flit_idx} and flit_idx increments.
  - Flits beyond MAX_FLITS are not written; pkt_flags is forced to PKT_DROP (truncate).
  - EOP → META. A SOP arriving in RECV is treated as an implicit EOP of the current packet: flags=PKT_DROP, the new SOP flit is discarded, go to META.
- META:
  - in_pkt_ready = 0. meta_valid=1 holds meta_data stable until meta_ready; then return to IDLE.
  - meta_data fields: flits=min(count,MAX_FLITS); len=flits*64−last_empty (16-bit); pktID.
- DISCARD: in_pkt_ready=1; consume until EOP, then IDLE.
- Write path:
  - registered; pkt_buffer_write asserts the cycle after acceptance; address/data valid with it.
  - Written flit's eop is forced to 1 on the last stored flit of a truncated packet.
- Latency: EOP accepted at cycle N → last write at N+1 → meta_valid at N+2.
- Throughput: one flit/cycle inside a packet, plus one META bubble per packet when meta_ready=1.
- Simultaneous pop and consume of id_r in the same cycle is legal (back-to-back packets).

Optional Feature:
- Macro PKT_WRITER_STATS_EN.
- Defined: stat_pkt_cnt increments per metadata handshake; stat_drop_cnt increments per SOP dropped for no ID. Both are 32-bit, wrap on overflow, and cleared by reset.
- Undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Shared constants package holds flit_t, metadata_t, PKT_AWIDTH, PKTBUF_AWIDTH, PKT_NUM, PKT_ETH/PKT_PCIE/PKT_DROP.
- One natural sub-module: pkt_id_prefetch (single-entry emptylist skid register).

Test Plan:
- Free ID 5 available; 3-flit packet, flags PKT_PCIE, EOP empty 10 → writes at 160,161,162 (eop on 162); meta {pktID 5, flits 3, len 182, PKT_PCIE}.
- Emptylist empty; 2-flit packet → no writes, no meta, stat_drop_cnt=1; next packet with ID 7 → stored normally.
- 40-flit packet with ID 2 → 31 writes at 64..94, last carries eop=1; meta flits 31, pkt_flags PKT_DROP.
- meta_ready held 0 for 20 cycles after a packet → in_pkt_ready=0 throughout, meta_data stable; on release, next packet accepted the following cycle.
- Back-to-back single-flit packets with IDs 1,2,3 preloaded → three writes at 32, 64, 96 and three metas, one bubble each.
- rst_n asserted mid-RECV → outputs 0 immediately; after release, IDLE with a fresh ID pop.

Source files
------------

// File: rtl/pkt_buffer_writer_pkg.sv
// Shared constants and types for the packet buffer ingress writer.
//   - Packet ID and buffer address widths (a packet slot holds 32 flits).
//   - flit_t: one stored flit {data, sop, eop, empty}.
//   - metadata_t: per-packet descriptor handed to the data mover.
//   - Destination flag encodings and FSM state encodings.
package pkt_buffer_writer_pkg;

  localparam int PKT_AWIDTH    = 9;
  localparam int PKT_NUM       = 1 << PKT_AWIDTH;
  localparam int FLIT_IDX_W    = 5;
  localparam int PKTBUF_AWIDTH = PKT_AWIDTH + FLIT_IDX_W;
  localparam int FLIT_DATA_W   = 512;
  localparam int EMPTY_W       = 6;
  localparam int FLAG_W        = 3;
  localparam int LEN_W         = 16;

  localparam logic [FLAG_W-1:0] PKT_ETH  = 3'b001;
  localparam logic [FLAG_W-1:0] PKT_PCIE = 3'b010;
  localparam logic [FLAG_W-1:0] PKT_DROP = 3'b100;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECV    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_META    = 2'd3;

  typedef struct packed {
    logic [FLIT_DATA_W-1:0] data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_W-1:0]     empty;
  } flit_t;

  typedef struct packed {
    logic [PKT_AWIDTH-1:0] pkt_id;
    logic [FLIT_IDX_W-1:0] flits;
    logic [LEN_W-1:0]      len;
    logic [FLAG_W-1:0]     pkt_flags;
  } metadata_t;

  // Byte length of a packet: every stored flit is 64 bytes except that the
  // last one gives back its empty bytes.
  function automatic logic [LEN_W-1:0] calc_len(input logic [FLIT_IDX_W-1:0] flits,
                                                input logic [EMPTY_W-1:0]    empty);
    return {5'd0, flits, 6'd0} - {10'd0, empty};
  endfunction

endpackage

// File: rtl/pkt_id_prefetch.sv
// Single-entry prefetch register in front of the packet emptylist.
// Holds one free packet ID so an SOP flit can be stored without waiting.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                allows popping (low right after reset)
//   consume               the held ID is taken this cycle
//   emptylist_out_data    free ID offered by the emptylist
//   emptylist_out_valid   emptylist has a free ID
//   emptylist_out_ready   pop strobe back to the emptylist
//   id, id_valid          held ID and its valid flag
// Handshake: a pop happens on a rising edge where emptylist_out_valid and
// emptylist_out_ready are both high; id_valid reflects it from the next cycle.
module pkt_id_prefetch
  import pkt_buffer_writer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  consume,
  input  logic [PKT_AWIDTH-1:0] emptylist_out_data,
  input  logic                  emptylist_out_valid,
  output logic                  emptylist_out_ready,
  output logic [PKT_AWIDTH-1:0] id,
  output logic                  id_valid
);

  logic pop;

  // Refill in the same cycle the held ID leaves, so back-to-back packets
  // never stall on the prefetch register.
  assign emptylist_out_ready = enable & (~id_valid | consume);
  assign pop                 = emptylist_out_valid & emptylist_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id       <= '0;
      id_valid <= 1'b0;
    end else if (pop) begin
      id       <= emptylist_out_data;
      id_valid <= 1'b1;
    end else if (consume) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pkt_buffer_writer.sv
// Ingress writer for the on-chip packet buffer.
// Takes an Ethernet RX flit stream, allocates a free packet ID from the
// emptylist, writes flit i of the packet to address {pkt_id, i} and, once the
// packet is complete, presents one metadata_t to the data mover.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_pkt_*                   RX flit stream (valid/ready)
//   emptylist_out_*            free packet ID source (valid/ready pop)
//   pkt_buffer_address/write/writedata   registered buffer write port
//   meta_valid/meta_data/meta_ready      packet descriptor (valid/ready)
//   stat_pkt_cnt, stat_drop_cnt          statistics counters
//   dbg_state                  current FSM state
// Valid/ready rule for every stream: a transfer happens on a rising edge where
// valid and ready are both high; a source holds valid and payload stable until
// that edge.
// Optional build macro PKT_WRITER_STATS_EN enables the statistics counters;
// without it both counters read 0 and no counter flops exist.
module pkt_buffer_writer
  import pkt_buffer_writer_pkg::*;
#(
  parameter int                MAX_FLITS    = 31,
  parameter logic [FLAG_W-1:0] FLAG_DEFAULT = PKT_ETH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_pkt_sop,
  input  logic                     in_pkt_eop,
  input  logic                     in_pkt_valid,
  input  logic [FLIT_DATA_W-1:0]   in_pkt_data,
  input  logic [EMPTY_W-1:0]       in_pkt_empty,
  input  logic [FLAG_W-1:0]        in_pkt_flags,
  input  logic                     in_pkt_flags_valid,
  output logic                     in_pkt_ready,
  input  logic [PKT_AWIDTH-1:0]    emptylist_out_data,
  input  logic                     emptylist_out_valid,
  output logic                     emptylist_out_ready,
  output logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address,
  output logic                     pkt_buffer_write,
  output flit_t                    pkt_buffer_writedata,
  output logic                     meta_valid,
  output metadata_t                meta_data,
  input  logic                     meta_ready,
  output logic [31:0]              stat_pkt_cnt,
  output logic [31:0]              stat_drop_cnt,
  output logic [1:0]               dbg_state
);

  localparam logic [5:0] MAX_IDX  = 6'(MAX_FLITS);
  localparam logic [5:0] LAST_IDX = 6'(MAX_FLITS - 1);

  logic                     run_q;
  logic [1:0]               state_q;
  logic [5:0]               flit_idx_q;
  logic [PKT_AWIDTH-1:0]    pkt_id_q;
  logic [FLAG_W-1:0]        flags_q;
  logic [EMPTY_W-1:0]       last_empty_q;
  logic                     wr_q;
  logic [PKTBUF_AWIDTH-1:0] wr_addr_q;
  flit_t                    wr_data_q;
  logic                     meta_valid_q;

  logic [PKT_AWIDTH-1:0]    id;
  logic                     id_valid;
  logic                     accept;
  logic                     sop_take;
  logic                     consume;
  logic                     drop_sop;
  logic                     recv_acc;
  logic                     recv_store;
  logic                     meta_fire;

  // run_q keeps both ready outputs low while in reset and for the first
  // cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  pkt_id_prefetch u_prefetch (
    .clk                 (clk),
    .rst_n               (rst_n),
    .enable              (run_q),
    .consume             (consume),
    .emptylist_out_data  (emptylist_out_data),
    .emptylist_out_valid (emptylist_out_valid),
    .emptylist_out_ready (emptylist_out_ready),
    .id                  (id),
    .id_valid            (id_valid)
  );

  assign in_pkt_ready = run_q & (state_q != ST_META);
  assign accept       = in_pkt_valid & in_pkt_ready;
  assign sop_take     = (state_q == ST_IDLE) & accept & in_pkt_sop;
  assign consume      = sop_take & id_valid;
  assign drop_sop     = sop_take & ~id_valid;
  assign recv_acc     = (state_q == ST_RECV) & accept;
  assign recv_store   = recv_acc & ~in_pkt_sop & (flit_idx_q < MAX_IDX);
  assign meta_fire    = meta_valid_q & meta_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flit_idx_q   <= '0;
      pkt_id_q     <= '0;
      flags_q      <= '0;
      last_empty_q <= '0;
      wr_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (consume) begin
            pkt_id_q        <= id;
            flags_q         <= in_pkt_flags_valid ? in_pkt_flags : FLAG_DEFAULT;
            flit_idx_q      <= 6'd1;
            last_empty_q    <= in_pkt_empty;
            wr_q            <= 1'b1;
            wr_addr_q       <= {id, 5'd0};
            wr_data_q.data  <= in_pkt_data;
            wr_data_q.sop   <= 1'b1;
            wr_data_q.eop   <= in_pkt_eop | (LAST_IDX == 6'd0);
            wr_data_q.empty <= in_pkt_empty;
            state_q         <= in_pkt_eop ? ST_META : ST_RECV;
          end else if (drop_sop && !in_pkt_eop) begin
            state_q <= ST_DISCARD;
          end
        end
        ST_RECV: begin
          if (recv_acc) begin
            if (in_pkt_sop) begin
              // A new SOP closes the current packet as a drop; the new
              // packet's first flit is lost.
              flags_q <= PKT_DROP;
              state_q <= ST_META;
            end else begin
              if (recv_store) begin
                flit_idx_q      <= flit_idx_q + 6'd1;
                last_empty_q    <= in_pkt_empty;
                wr_q            <= 1'b1;
                wr_addr_q       <= {pkt_id_q, flit_idx_q[FLIT_IDX_W-1:0]};
                wr_data_q.data  <= in_pkt_data;
                wr_data_q.sop   <= 1'b0;
                // The last slot always closes the stored packet, so a
                // truncated packet still ends with eop in the buffer.
                wr_data_q.eop   <= in_pkt_eop | (flit_idx_q == LAST_IDX);
                wr_data_q.empty <= in_pkt_empty;
              end else begin
                flags_q <= PKT_DROP;
              end
              if (in_pkt_eop) state_q <= ST_META;
            end
          end
        end
        ST_DISCARD: begin
          if (accept && in_pkt_eop) state_q <= ST_IDLE;
        end
        ST_META: begin
          if (meta_fire) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // meta_valid rises one cycle after entering META so the last buffer write
  // is already visible when the descriptor is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) meta_valid_q <= 1'b0;
    else        meta_valid_q <= (state_q == ST_META) & ~meta_fire;
  end

  assign pkt_buffer_write     = wr_q;
  assign pkt_buffer_address   = wr_addr_q;
  assign pkt_buffer_writedata = wr_data_q;
  assign meta_valid           = meta_valid_q;
  assign meta_data.pkt_id     = pkt_id_q;
  assign meta_data.flits      = flit_idx_q[FLIT_IDX_W-1:0];
  assign meta_data.len        = calc_len(flit_idx_q[FLIT_IDX_W-1:0], last_empty_q);
  assign meta_data.pkt_flags  = flags_q;
  assign dbg_state            = state_q;

`ifdef PKT_WRITER_STATS_EN
  logic [31:0] pkt_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (meta_fire) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
      if (drop_sop)  drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// Directed bench for pkt_buffer_writer.
module tb_pkt_buffer_writer;
  import pkt_buffer_writer_pkg::*;

`ifdef PKT_WRITER_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  localparam int MW = $bits(metadata_t);

  logic                     clk;
  logic                     rst_n;
  logic                     in_pkt_sop;
  logic                     in_pkt_eop;
  logic                     in_pkt_valid;
  logic [FLIT_DATA_W-1:0]   in_pkt_data;
  logic [EMPTY_W-1:0]       in_pkt_empty;
  logic [FLAG_W-1:0]        in_pkt_flags;
  logic                     in_pkt_flags_valid;
  logic                     in_pkt_ready;
  logic [PKT_AWIDTH-1:0]    emptylist_out_data;
  logic                     emptylist_out_valid;
  logic                     emptylist_out_ready;
  logic [PKTBUF_AWIDTH-1:0] pkt_buffer_address;
  logic                     pkt_buffer_write;
  flit_t                    pkt_buffer_writedata;
  logic                     meta_valid;
  metadata_t                meta_data;
  logic                     meta_ready;
  logic [31:0]              stat_pkt_cnt;
  logic [31:0]              stat_drop_cnt;
  logic [1:0]               dbg_state;

  pkt_buffer_writer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_pkt_sop           (in_pkt_sop),
    .in_pkt_eop           (in_pkt_eop),
    .in_pkt_valid         (in_pkt_valid),
    .in_pkt_data          (in_pkt_data),
    .in_pkt_empty         (in_pkt_empty),
    .in_pkt_flags         (in_pkt_flags),
    .in_pkt_flags_valid   (in_pkt_flags_valid),
    .in_pkt_ready         (in_pkt_ready),
    .emptylist_out_data   (emptylist_out_data),
    .emptylist_out_valid  (emptylist_out_valid),
    .emptylist_out_ready  (emptylist_out_ready),
    .pkt_buffer_address   (pkt_buffer_address),
    .pkt_buffer_write     (pkt_buffer_write),
    .pkt_buffer_writedata (pkt_buffer_writedata),
    .meta_valid           (meta_valid),
    .meta_data            (meta_data),
    .meta_ready           (meta_ready),
    .stat_pkt_cnt         (stat_pkt_cnt),
    .stat_drop_cnt        (stat_drop_cnt),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- counters and queues ----------------
  int total = 0;
  int bad   = 0;

  logic [PKT_AWIDTH-1:0] el_q[$];        // free IDs offered by the emptylist model
  logic [15:0]           exp_wr_q[$];    // {eop, address}
  logic [15:0]           obs_wr_q[$];
  logic [MW-1:0]         exp_q[$];       // expected metadata handshakes
  logic [MW-1:0]         obs_meta_q[$];
  logic [31:0]           obs_dat_q[$];
  int                    last_wr_cyc = 0;
  int                    meta_rise_cyc = 0;
  logic                  meta_prev = 1'b0;
  bit                    el_fire;

  // emptylist model: pops its head when the DUT takes it
  always @(posedge clk) begin
    el_fire = emptylist_out_valid && emptylist_out_ready;
    #1;
    if (el_fire && el_q.size() > 0) void'(el_q.pop_front());
    emptylist_out_valid = (el_q.size() > 0);
    emptylist_out_data  = (el_q.size() > 0) ? el_q[0] : '0;
  end

  // observation monitor, away from the active edge
  always @(negedge clk) begin
    if (pkt_buffer_write) begin
      obs_wr_q.push_back({1'b0, pkt_buffer_writedata.eop, pkt_buffer_address});
      obs_dat_q.push_back(pkt_buffer_writedata.data[31:0]);
      last_wr_cyc = cyc;
    end
    if (meta_valid && !meta_prev) meta_rise_cyc = cyc;
    meta_prev = meta_valid;
    if (meta_valid && meta_ready) obs_meta_q.push_back(meta_data);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk_meta(input int id, input int flits, input int len,
                                            input logic [2:0] flags);
    metadata_t m;
    m.pkt_id    = PKT_AWIDTH'(id);
    m.flits     = 5'(flits);
    m.len       = 16'(len);
    m.pkt_flags = flags;
    return m;
  endfunction

  function automatic logic [15:0] mk_wr(input int addr, input logic eop);
    return {1'b0, eop, 14'(addr)};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int acc_cyc = 0;

  // Present one flit and return one cycle after it is accepted.
  task automatic send_flit(input logic sop, input logic eop, input logic [5:0] empty,
                           input logic [2:0] flags, input logic fv, input logic [31:0] d);
    int w;
    w = 0;
    in_pkt_valid       = 1'b1;
    in_pkt_sop         = sop;
    in_pkt_eop         = eop;
    in_pkt_empty       = empty;
    in_pkt_flags       = flags;
    in_pkt_flags_valid = fv;
    in_pkt_data        = {480'd0, d};
    while (!in_pkt_ready && w < 100) begin
      step(1);
      w++;
    end
    if (w >= 100) chk("ready_timeout", 64'(in_pkt_ready), 64'd1);
    step(1);
    acc_cyc = cyc;
  endtask

  task automatic idle_in();
    in_pkt_valid = 1'b0;
    in_pkt_sop   = 1'b0;
    in_pkt_eop   = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_n"}, 64'(obs_wr_q.size()), 64'(exp_wr_q.size()));
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0)
      chk({tag, "_wr"}, 64'(obs_wr_q.pop_front()), 64'(exp_wr_q.pop_front()));
    exp_wr_q.delete();
    obs_wr_q.delete();
    obs_dat_q.delete();
  endtask

  task automatic check_metas(input string tag);
    chk({tag, "_meta_n"}, 64'(obs_meta_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_meta_q.size() > 0)
      chk({tag, "_meta"}, 64'(obs_meta_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_meta_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rdy_bad;
    int stab_bad;
    int w;
    logic [MW-1:0] hold_exp;

    rst_n      = 1'b0;
    meta_ready = 1'b1;
    emptylist_out_valid = 1'b0;
    emptylist_out_data  = '0;
    in_pkt_data        = '0;
    in_pkt_empty       = '0;
    in_pkt_flags       = '0;
    in_pkt_flags_valid = 1'b0;
    idle_in();
    step(3);

    // reset state
    chk("rst_in_ready", 64'(in_pkt_ready), 64'd0);
    chk("rst_el_ready", 64'(emptylist_out_ready), 64'd0);
    chk("rst_write", 64'(pkt_buffer_write), 64'd0);
    chk("rst_meta_valid", 64'(meta_valid), 64'd0);
    chk("rst_meta_data", 64'(meta_data), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_stat_pkt", 64'(stat_pkt_cnt), 64'd0);

    // 1: ID 5, 3-flit PCIe packet, empty 10 on EOP
    el_q.push_back(9'd5);
    rst_n = 1'b1;
    step(5);
    chk("t1_id_held", 64'(emptylist_out_ready), 64'd0);
    chk("t1_idle_ready", 64'(in_pkt_ready), 64'd1);
    send_flit(1, 0, 6'd0, PKT_PCIE, 1, 32'hA0);
    send_flit(0, 0, 6'd0, PKT_ETH, 0, 32'hA1);
    send_flit(0, 1, 6'd10, PKT_ETH, 0, 32'hA2);
    idle_in();
    chk("t1_meta_state", 64'(dbg_state), 64'(ST_META));
    chk("t1_meta_ready_low", 64'(in_pkt_ready), 64'd0);
    chk("t1_meta_not_yet", 64'(meta_valid), 64'd0);
    chk("t1_last_data", 64'(pkt_buffer_writedata.data[31:0]), 64'hA2);
    step(4);
    chk("t1_lat_write", 64'(last_wr_cyc - acc_cyc), 64'd0);
    chk("t1_lat_meta", 64'(meta_rise_cyc - acc_cyc), 64'd1);
    exp_wr_q = '{mk_wr(160, 0), mk_wr(161, 0), mk_wr(162, 1)};
    exp_q.push_back(mk_meta(5, 3, 182, PKT_PCIE));
    check_writes("t1");
    check_metas("t1");

    // 2: no free ID -> packet dropped; then ID 7 stores normally
    send_flit(1, 0, 6'd0, PKT_PCIE, 1, 32'hB0);
    send_flit(0, 1, 6'd3, PKT_ETH, 0, 32'hB1);
    idle_in();
    step(4);
    chk("t2_drop_cnt", 64'(stat_drop_cnt), 64'(STATS_ON));
    chk("t2_drop_state", 64'(dbg_state), 64'(ST_IDLE));
    check_writes("t2_drop");
    check_metas("t2_drop");
    el_q.push_back(9'd7);
    step(4);
    send_flit(1, 0, 6'd0, PKT_PCIE, 0, 32'hC0);
    send_flit(0, 1, 6'd4, PKT_PCIE, 0, 32'hC1);
    idle_in();
    step(4);
    exp_wr_q = '{mk_wr(224, 0), mk_wr(225, 1)};
    exp_q.push_back(mk_meta(7, 2, 124, PKT_ETH));
    check_writes("t2");
    check_metas("t2");

    // 3: 40-flit packet with ID 2 -> truncated to 31 flits
    el_q.push_back(9'd2);
    step(4);
    for (int i = 0; i < 40; i++)
      send_flit(i == 0, i == 39, 6'd0, PKT_ETH, 1, 32'(i));
    idle_in();
    step(4);
    for (int i = 0; i < 31; i++) exp_wr_q.push_back(mk_wr(64 + i, i == 30));
    exp_q.push_back(mk_meta(2, 31, 1984, PKT_DROP));
    check_writes("t3");
    check_metas("t3");
    chk("t3_pkt_cnt", 64'(stat_pkt_cnt), 64'(3 * STATS_ON));

    // 4: meta_ready held low for 20 cycles, next packet pending
    el_q.push_back(9'd4);
    el_q.push_back(9'd6);
    step(4);
    meta_ready = 1'b0;
    send_flit(1, 1, 6'd0, PKT_PCIE, 1, 32'hD0);
    in_pkt_sop         = 1'b1;
    in_pkt_eop         = 1'b1;
    in_pkt_flags_valid = 1'b0;
    in_pkt_data        = {480'd0, 32'hD1};
    w = 0;
    while (!meta_valid && w < 20) begin
      step(1);
      w++;
    end
    chk("t4_meta_up", 64'(meta_valid), 64'd1);
    hold_exp = mk_meta(4, 1, 64, PKT_PCIE);
    rdy_bad  = 0;
    stab_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (in_pkt_ready !== 1'b0) rdy_bad++;
      if (meta_data !== hold_exp || meta_valid !== 1'b1) stab_bad++;
    end
    chk("t4_hold_ready_low", 64'(rdy_bad), 64'd0);
    chk("t4_hold_meta_stable", 64'(stab_bad), 64'd0);
    chk("t4_hold_no_write", 64'(obs_wr_q.size()), 64'd1);
    meta_ready = 1'b1;
    step(1);
    chk("t4_release_ready", 64'(in_pkt_ready), 64'd1);
    step(1);
    idle_in();
    chk("t4_next_write", 64'(pkt_buffer_write), 64'd1);
    chk("t4_next_addr", 64'(pkt_buffer_address), 64'd192);
    step(5);
    exp_wr_q = '{mk_wr(128, 1), mk_wr(192, 1)};
    exp_q.push_back(hold_exp);
    exp_q.push_back(mk_meta(6, 1, 64, PKT_ETH));
    check_writes("t4");
    check_metas("t4");

    // 5: back-to-back single-flit packets, IDs 1,2,3
    el_q.push_back(9'd1);
    el_q.push_back(9'd2);
    el_q.push_back(9'd3);
    step(4);
    send_flit(1, 1, 6'd0, PKT_ETH, 0, 32'hE1);
    send_flit(1, 1, 6'd0, PKT_ETH, 0, 32'hE2);
    send_flit(1, 1, 6'd0, PKT_ETH, 0, 32'hE3);
    idle_in();
    step(5);
    exp_wr_q = '{mk_wr(32, 1), mk_wr(64, 1), mk_wr(96, 1)};
    for (int i = 1; i <= 3; i++) exp_q.push_back(mk_meta(i, 1, 64, PKT_ETH));
    check_writes("t5");
    check_metas("t5");

    // 6: reset in the middle of a packet
    el_q.push_back(9'd9);
    step(4);
    send_flit(1, 0, 6'd0, PKT_ETH, 0, 32'hF0);
    send_flit(0, 0, 6'd0, PKT_ETH, 0, 32'hF1);
    chk("t6_in_recv", 64'(dbg_state), 64'(ST_RECV));
    rst_n = 1'b0;
    idle_in();
    #1;
    chk("t6_rst_in_ready", 64'(in_pkt_ready), 64'd0);
    chk("t6_rst_write", 64'(pkt_buffer_write), 64'd0);
    chk("t6_rst_addr", 64'(pkt_buffer_address), 64'd0);
    chk("t6_rst_meta_data", 64'(meta_data), 64'd0);
    chk("t6_rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("t6_rst_drop_cnt", 64'(stat_drop_cnt), 64'd0);
    chk("t6_rst_pkt_cnt", 64'(stat_pkt_cnt), 64'd0);
    step(2);
    obs_wr_q.delete();
    obs_dat_q.delete();
    obs_meta_q.delete();
    el_q.delete();
    el_q.push_back(9'd11);
    rst_n = 1'b1;
    step(5);
    chk("t6_fresh_pop", 64'(el_q.size()), 64'd0);
    chk("t6_id_held", 64'(emptylist_out_ready), 64'd0);
    chk("t6_idle", 64'(dbg_state), 64'(ST_IDLE));
    send_flit(1, 1, 6'd0, PKT_ETH, 0, 32'hF2);
    idle_in();
    step(5);
    exp_wr_q = '{mk_wr(352, 1)};
    exp_q.push_back(mk_meta(11, 1, 64, PKT_ETH));
    check_writes("t6");
    check_metas("t6");

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
